alu_issue: RTL and testbench

Registered decode/issue stage that drives the `ALU_top` operand and function-select inputs (A, B, FS) from RISC-V RV32I instructions. It accepts one instruction per cycle with its PC and register-file operands over a valid/ready handshake. It decodes OP, OP-IMM, LUI, AUIPC and BRANCH instructions into ALU operands and a 4-bit FS code, and presents them downstream through a 2-entry skid buffer. Position: between register-file read and the ALU/execute stage.

---
 rtl/alu_issue.sv | 186 ++++++++++++++++++
 tb/tb_alu_issue.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// RV32I decode/issue stage feeding ALU operands (A, B, FS) through a 2-entry skid buffer.
// Decode is combinational on the input side; only decoded fields are registered.
module alu_issue #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [3:0]      out_fs,
  output logic [4:0]      out_rd,
  output logic            out_wb_en,
  output logic            out_branch,
  output logic            out_br_inv,
  output logic            out_illegal
);

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [3:0]      fs;
    logic [4:0]      rd;
    logic            wb_en;
    logic            branch;
    logic            br_inv;
    logic            illegal;
  } entry_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // funct3 to FS for the shared OP / OP-IMM arithmetic group (funct7 = 0 flavour)
  function automatic logic [3:0] arith_fs(input logic [2:0] f3);
    case (f3)
      3'b000:  arith_fs = 4'd3;
      3'b001:  arith_fs = 4'd0;
      3'b010:  arith_fs = 4'd12;
      3'b011:  arith_fs = 4'd13;
      3'b100:  arith_fs = 4'd7;
      3'b101:  arith_fs = 4'd1;
      3'b110:  arith_fs = 4'd6;
      default: arith_fs = 4'd5;
    endcase
  endfunction

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       legal;
  entry_t     dec_p0;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  // Stage p0: combinational decode of the incoming instruction
  always_comb begin
    dec_p0         = '0;
    dec_p0.a       = in_rs1_data;
    dec_p0.fs      = 4'd8;
    dec_p0.rd      = in_instr[11:7];
    legal          = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec_p0.b = in_rs2_data;
        if (funct7 == 7'b0000000) begin
          dec_p0.fs = arith_fs(funct3);
          legal     = 1'b1;
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          dec_p0.fs = 4'd4;
          legal     = 1'b1;
        end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
          dec_p0.fs = 4'd2;
          legal     = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        dec_p0.b  = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
        dec_p0.fs = arith_fs(funct3);
        legal     = 1'b1;
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          dec_p0.b = {{(XLEN-5){1'b0}}, in_instr[24:20]};
          if (funct7 == 7'b0100000 && funct3 == 3'b101) dec_p0.fs = 4'd2;
          else if (funct7 != 7'b0000000)                legal     = 1'b0;
        end
      end
      OPC_LUI: begin
        dec_p0.b  = {in_instr[31:12], 12'b0};
        dec_p0.fs = 4'd9;
        legal     = 1'b1;
      end
      OPC_AUIPC: begin
        dec_p0.a  = in_pc;
        dec_p0.b  = {in_instr[31:12], 12'b0};
        dec_p0.fs = 4'd3;
        legal     = 1'b1;
      end
      OPC_BRANCH: begin
        dec_p0.b      = in_rs2_data;
        dec_p0.branch = 1'b1;
        dec_p0.br_inv = funct3[0];
        legal         = (funct3[2:1] != 2'b01);
        case (funct3[2:1])
          2'b00:   dec_p0.fs = 4'd14;
          2'b10:   dec_p0.fs = 4'd12;
          default: dec_p0.fs = 4'd13;
        endcase
      end
      default: legal = 1'b0;
    endcase
    // Unsupported encodings still issue, as a pass-A with no side effects
    if (!legal) begin
      dec_p0.a      = in_rs1_data;
      dec_p0.b      = '0;
      dec_p0.fs     = 4'd8;
      dec_p0.branch = 1'b0;
      dec_p0.br_inv = 1'b0;
    end
    dec_p0.illegal = !legal;
    dec_p0.wb_en   = legal && !dec_p0.branch && (dec_p0.rd != 5'd0);
  end

  entry_t out_ent_p1;
  entry_t skid_ent_p1;
  logic   vld_p1;
  logic   skid_vld_p1;
  logic   in_xfer;
  logic   out_xfer;

  assign in_ready = !skid_vld_p1;
  assign in_xfer  = in_valid && !skid_vld_p1;
  assign out_xfer = vld_p1 && out_ready;

  // Stage p1: output register plus skid register, drained in arrival order
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
      out_ent_p1  <= '0;
      skid_ent_p1 <= '0;
    end else if (flush) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
    end else if (!vld_p1) begin
      if (in_xfer) begin
        out_ent_p1 <= dec_p0;
        vld_p1     <= 1'b1;
      end
    end else if (!skid_vld_p1) begin
      if (in_xfer && out_xfer) begin
        out_ent_p1 <= dec_p0;
      end else if (in_xfer) begin
        skid_ent_p1 <= dec_p0;
        skid_vld_p1 <= 1'b1;
      end else if (out_xfer) begin
        vld_p1 <= 1'b0;
      end
    end else if (out_xfer) begin
      out_ent_p1  <= skid_ent_p1;
      skid_vld_p1 <= 1'b0;
    end
  end

  assign out_valid   = vld_p1;
  assign out_a       = out_ent_p1.a;
  assign out_b       = out_ent_p1.b;
  assign out_fs      = out_ent_p1.fs;
  assign out_rd      = out_ent_p1.rd;
  assign out_wb_en   = out_ent_p1.wb_en;
  assign out_branch  = out_ent_p1.branch;
  assign out_br_inv  = out_ent_p1.br_inv;
  assign out_illegal = out_ent_p1.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: decode vectors, backpressure ordering, flush and async reset.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [3:0]  out_fs;
  logic [4:0]  out_rd;
  logic        out_wb_en;
  logic        out_branch;
  logic        out_br_inv;
  logic        out_illegal;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_issue #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
    .out_fs(out_fs), .out_rd(out_rd), .out_wb_en(out_wb_en), .out_branch(out_branch),
    .out_br_inv(out_br_inv), .out_illegal(out_illegal)
  );

  task automatic present(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] rs1, input logic [31:0] rs2);
    in_valid    = 1'b1;
    in_instr    = instr;
    in_pc       = pc;
    in_rs1_data = rs1;
    in_rs2_data = rs2;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [82:0] got;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0; in_rs1_data = '0; in_rs2_data = '0;
    #12;
    got = {out_valid, out_a, out_b, out_fs, out_rd, out_wb_en, out_branch, out_br_inv, out_illegal};
    n_vec++;
    if (got !== '0) begin
      $display("FAIL reset_outputs got=%h want=0", got); n_bad++;
    end
    n_vec++;
    if (in_ready !== 1'b1) begin
      $display("FAIL reset_in_ready got=%b want=1", in_ready); n_bad++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    #4;
  endtask

  task automatic test_add;
    out_ready = 1'b1;
    present(32'h002081B3, 32'h0, 32'd5, 32'd7);
    step();
    in_valid = 1'b0;
    n_vec++;
    if ({out_valid, out_a, out_b, out_fs, out_rd, out_wb_en} !== {1'b1, 32'd5, 32'd7, 4'd3, 5'd3, 1'b1}) begin
      $display("FAIL add v=%b a=%h b=%h fs=%0d rd=%0d wb=%b want 1 5 7 3 3 1",
               out_valid, out_a, out_b, out_fs, out_rd, out_wb_en); n_bad++;
    end
    step();
    n_vec++;
    if (out_valid !== 1'b0) begin
      $display("FAIL add_drain out_valid got=%b want=0", out_valid); n_bad++;
    end
  endtask

  typedef struct {
    logic [31:0] instr, pc, rs1, rs2, a, b;
    logic [3:0]  fs;
    logic [4:0]  rd;
    logic        wb, br, inv, ill;
  } vec_t;

  task automatic test_decode;
    vec_t v[13];
    v[0]  = '{32'h4030D213, 0, 32'h80000000, 9, 32'h80000000, 3, 2, 4, 1, 0, 0, 0};          // srai x4,x1,3
    v[1]  = '{32'h402081B3, 0, 10, 3, 10, 3, 4, 3, 1, 0, 0, 0};                              // sub
    v[2]  = '{32'h0020D463, 0, 11, 22, 11, 22, 12, 8, 0, 1, 1, 0};                           // bge
    v[3]  = '{32'h123452B7, 0, 0, 0, 0, 32'h12345000, 9, 5, 1, 0, 0, 0};                     // lui
    v[4]  = '{32'h00001317, 32'h100, 77, 88, 32'h100, 32'h1000, 3, 6, 1, 0, 0, 0};           // auipc
    v[5]  = '{32'hFFF00093, 0, 0, 0, 0, 32'hFFFFFFFF, 3, 1, 1, 0, 0, 0};                     // addi -1
    v[6]  = '{32'h0000007F, 0, 32'h55, 32'h66, 32'h55, 0, 8, 0, 0, 0, 0, 1};                 // bad opcode
    v[7]  = '{32'h4020F1B3, 0, 32'h12, 32'h34, 32'h12, 0, 8, 3, 0, 0, 0, 1};                 // OP f7=0100000 f3=111
    v[8]  = '{32'h0020F033, 0, 6, 3, 6, 3, 5, 0, 0, 0, 0, 0};                                // and x0 -> no wb
    v[9]  = '{32'h0020E463, 0, 1, 2, 1, 2, 13, 8, 0, 1, 0, 0};                               // bltu
    v[10] = '{32'h02109093, 0, 32'hA, 0, 32'hA, 0, 8, 1, 0, 0, 0, 1};                        // slli bad f7
    v[11] = '{32'h0020B1B3, 0, 4, 5, 4, 5, 13, 3, 1, 0, 0, 0};                               // sltu
    v[12] = '{32'h0020A463, 0, 7, 8, 7, 0, 8, 8, 0, 0, 0, 1};                                // branch f3=010
    out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      present(v[i].instr, v[i].pc, v[i].rs1, v[i].rs2);
      step();
      n_vec++;
      if ({out_valid, out_a, out_b, out_fs, out_rd, out_wb_en, out_branch, out_br_inv, out_illegal} !==
          {1'b1, v[i].a, v[i].b, v[i].fs, v[i].rd, v[i].wb, v[i].br, v[i].inv, v[i].ill}) begin
        $display("FAIL decode[%0d] instr=%h got v=%b a=%h b=%h fs=%0d rd=%0d wb=%b br=%b inv=%b ill=%b want a=%h b=%h fs=%0d rd=%0d wb=%b br=%b inv=%b ill=%b",
                 i, v[i].instr, out_valid, out_a, out_b, out_fs, out_rd, out_wb_en, out_branch, out_br_inv, out_illegal,
                 v[i].a, v[i].b, v[i].fs, v[i].rd, v[i].wb, v[i].br, v[i].inv, v[i].ill);
        n_bad++;
      end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b0;
    present(32'h002081B3, 0, 1, 0);
    step();
    n_vec++;
    if ({out_valid, out_a, in_ready} !== {1'b1, 32'd1, 1'b1}) begin
      $display("FAIL bp_one v=%b a=%h rdy=%b want 1 1 1", out_valid, out_a, in_ready); n_bad++;
    end
    present(32'h002081B3, 0, 2, 0);
    step();
    n_vec++;
    if ({out_valid, out_a, in_ready} !== {1'b1, 32'd1, 1'b0}) begin
      $display("FAIL bp_full v=%b a=%h rdy=%b want 1 1 0", out_valid, out_a, in_ready); n_bad++;
    end
    present(32'h002081B3, 0, 3, 0);
    step();
    n_vec++;
    if ({out_valid, out_a, out_fs, out_rd, in_ready} !== {1'b1, 32'd1, 4'd3, 5'd3, 1'b0}) begin
      $display("FAIL bp_hold v=%b a=%h fs=%0d rd=%0d rdy=%b want 1 1 3 3 0",
               out_valid, out_a, out_fs, out_rd, in_ready); n_bad++;
    end
    out_ready = 1'b1;
    step();
    n_vec++;
    if ({out_valid, out_a, in_ready} !== {1'b1, 32'd2, 1'b1}) begin
      $display("FAIL bp_second v=%b a=%h rdy=%b want 1 2 1", out_valid, out_a, in_ready); n_bad++;
    end
    step();
    in_valid = 1'b0;
    n_vec++;
    if ({out_valid, out_a} !== {1'b1, 32'd3}) begin
      $display("FAIL bp_third v=%b a=%h want 1 3", out_valid, out_a); n_bad++;
    end
    step();
    n_vec++;
    if (out_valid !== 1'b0) begin
      $display("FAIL bp_empty out_valid got=%b want=0", out_valid); n_bad++;
    end
  endtask

  task automatic test_flush;
    out_ready = 1'b0;
    present(32'h002081B3, 0, 1, 0);
    step();
    present(32'h002081B3, 0, 2, 0);
    step();
    present(32'h002081B3, 0, 3, 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    n_vec++;
    if ({out_valid, in_ready} !== 2'b01) begin
      $display("FAIL flush v=%b rdy=%b want 0 1", out_valid, in_ready); n_bad++;
    end
    out_ready = 1'b1;
    step();
    n_vec++;
    if (out_valid !== 1'b0) begin
      $display("FAIL flush_discard out_valid got=%b want=0", out_valid); n_bad++;
    end
  endtask

  task automatic test_async_reset;
    logic [82:0] got;
    out_ready = 1'b0;
    present(32'h0020D463, 0, 32'hDEAD, 32'hBEEF);
    step();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    got = {out_valid, out_a, out_b, out_fs, out_rd, out_wb_en, out_branch, out_br_inv, out_illegal};
    n_vec++;
    if (got !== '0 || in_ready !== 1'b1) begin
      $display("FAIL async_reset got=%h rdy=%b want 0 1", got, in_ready); n_bad++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    present(32'h123452B7, 0, 0, 0);
    step();
    in_valid = 1'b0;
    n_vec++;
    if ({out_valid, out_b, out_fs} !== {1'b1, 32'h12345000, 4'd9}) begin
      $display("FAIL post_reset v=%b b=%h fs=%0d want 1 12345000 9", out_valid, out_b, out_fs); n_bad++;
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_decode();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
